// File: rtl/fft_frame_sched.sv
// Frame scheduler: runs RX fill, FFT compute, TX drain in order and owns the FFT memory port select.
// Latency: every output is registered; a request rises one cycle after its REQ state is chosen.
// Backpressure: requests are held until the sub-block raises busy; a phase ends on busy falling.
// Optional watchdog: define FFT_SCHED_WDOG_EN to time out REQ/RUN phases after WDOG_CYC cycles.
module fft_frame_sched #(
  parameter int FRAME_CNT_WDT = 16,
  parameter int WDOG_CYC      = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_en,
  input  logic [FRAME_CNT_WDT-1:0] cfg_frames,
  input  logic                     cfg_clr_err,
  output logic                     rx_start,
  input  logic                     rx_busy,
  output logic                     fft_start,
  input  logic                     fft_busy,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [1:0]               mem_sel,
  output logic [1:0]               phase,
  output logic                     sched_busy,
  output logic                     frame_done,
  output logic [FRAME_CNT_WDT-1:0] frames_done,
  output logic                     all_done,
  output logic                     err
);

  typedef enum logic [3:0] {
    IDLE, RX_REQ, RX_RUN, FFT_REQ, FFT_RUN, TX_REQ, TX_RUN, DONE, ERR
  } state_t;

  state_t                   state;
  logic [FRAME_CNT_WDT-1:0] frames_inc;
  logic                     wdog_hit;

  assign frames_inc = frames_done + 1'b1;

`ifdef FFT_SCHED_WDOG_EN
  logic [31:0] wdog_cnt;
  logic [31:0] wdog_eff;
  state_t      state_prev;
  logic        wdog_act;

  // The stored count is stale on the first cycle of a state, so that cycle is treated as count 0.
  assign wdog_act = state inside {RX_REQ, RX_RUN, FFT_REQ, FFT_RUN, TX_REQ, TX_RUN};
  assign wdog_eff = (state != state_prev) ? 32'd0 : wdog_cnt;
  assign wdog_hit = wdog_act && (wdog_eff == 32'(WDOG_CYC - 1));

  // Watchdog count of cycles spent in the current REQ/RUN state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt   <= '0;
      state_prev <= IDLE;
    end else begin
      state_prev <= state;
      wdog_cnt   <= wdog_act ? wdog_eff + 32'd1 : 32'd0;
    end
  end
`else
  logic unused_cfg;
  assign wdog_hit   = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = cfg_clr_err ^ (WDOG_CYC == 0);
`endif

  // Frame state machine; all outputs are set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_start    <= 1'b0;
      fft_start   <= 1'b0;
      tx_start    <= 1'b0;
      mem_sel     <= 2'd0;
      phase       <= 2'd0;
      sched_busy  <= 1'b0;
      frame_done  <= 1'b0;
      frames_done <= '0;
      all_done    <= 1'b0;
`ifdef FFT_SCHED_WDOG_EN
      err         <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (wdog_hit) begin
        state      <= ERR;
        rx_start   <= 1'b0;
        fft_start  <= 1'b0;
        tx_start   <= 1'b0;
        mem_sel    <= 2'd0;
        phase      <= 2'd0;
        sched_busy <= 1'b0;
`ifdef FFT_SCHED_WDOG_EN
        err        <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: if (cfg_en) begin
            state       <= RX_REQ;
            rx_start    <= 1'b1;
            mem_sel     <= 2'd1;
            phase       <= 2'd1;
            sched_busy  <= 1'b1;
            frames_done <= '0;
          end
          RX_REQ: if (rx_busy) begin
            state    <= RX_RUN;
            rx_start <= 1'b0;
          end
          RX_RUN: if (!rx_busy) begin
            state     <= FFT_REQ;
            fft_start <= 1'b1;
            mem_sel   <= 2'd2;
            phase     <= 2'd2;
          end
          FFT_REQ: if (fft_busy) begin
            state     <= FFT_RUN;
            fft_start <= 1'b0;
          end
          FFT_RUN: if (!fft_busy) begin
            state    <= TX_REQ;
            tx_start <= 1'b1;
            mem_sel  <= 2'd3;
            phase    <= 2'd3;
          end
          TX_REQ: if (tx_busy) begin
            state    <= TX_RUN;
            tx_start <= 1'b0;
          end
          TX_RUN: if (!tx_busy) begin
            frame_done  <= 1'b1;
            frames_done <= frames_inc;
            if ((cfg_frames != '0) && (frames_inc == cfg_frames)) begin
              state      <= DONE;
              mem_sel    <= 2'd0;
              phase      <= 2'd0;
              sched_busy <= 1'b0;
              all_done   <= 1'b1;
            end else if (cfg_en) begin
              state    <= RX_REQ;
              rx_start <= 1'b1;
              mem_sel  <= 2'd1;
              phase    <= 2'd1;
            end else begin
              state      <= IDLE;
              mem_sel    <= 2'd0;
              phase      <= 2'd0;
              sched_busy <= 1'b0;
            end
          end
          DONE: if (!cfg_en) begin
            state    <= IDLE;
            all_done <= 1'b0;
          end
          ERR: begin
`ifdef FFT_SCHED_WDOG_EN
            if (cfg_clr_err) begin
              state <= IDLE;
              err   <= 1'b0;
            end
`else
            state <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched with behavioural RX/FFT/TX busy models and a negedge monitor.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there or on the falling edge.
// Backpressure: the TX model stretches busy with random stalls plus a held-last-beat tail.
module tb_fft_frame_sched;

  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic [FW-1:0] cfg_frames;
  logic          cfg_clr_err;
  logic          rx_start, fft_start, tx_start;
  logic          rx_busy  = 1'b0;
  logic          fft_busy = 1'b0;
  logic          tx_busy  = 1'b0;
  logic [1:0]    mem_sel, phase;
  logic          sched_busy, frame_done, all_done, err;
  logic [FW-1:0] frames_done;
  logic [14:0]   all_outs;

  int n_chk = 0;
  int n_bad = 0;

  bit fft_en  = 1'b1;
  bit tx_rand = 1'b0;

  // monitor state (written only by the monitor process)
  int         n_fd   = 0;
  int         n_ovl  = 0;
  int         n_early = 0;
  int         n_done_cyc = 0;
  logic       prev_txb = 1'b0;
  logic [1:0] prev_ms  = 2'd0;
  logic [2:0] prev_st  = 3'd0;
  logic [1:0] ms_log[$];
  logic [1:0] st_log[$];

  fft_frame_sched #(.FRAME_CNT_WDT(FW), .WDOG_CYC(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en      (cfg_en),
    .cfg_frames  (cfg_frames),
    .cfg_clr_err (cfg_clr_err),
    .rx_start    (rx_start),
    .rx_busy     (rx_busy),
    .fft_start   (fft_start),
    .fft_busy    (fft_busy),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .mem_sel     (mem_sel),
    .phase       (phase),
    .sched_busy  (sched_busy),
    .frame_done  (frame_done),
    .frames_done (frames_done),
    .all_done    (all_done),
    .err         (err)
  );

  assign all_outs = {rx_start, fft_start, tx_start, mem_sel, phase, sched_busy,
                     frame_done, frames_done, all_done, err};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !all_done; i++) tick();
  endtask

  // RX slave IF: busy 10 cycles, starting 2 cycles after the request is seen
  always begin : rx_model
    tick();
    if (rx_start && !rx_busy) begin
      tick_n(2);
      rx_busy = 1'b1;
      tick_n(10);
      rx_busy = 1'b0;
    end
  end

  // FFT engine: same profile; can be silenced to exercise the watchdog
  always begin : fft_model
    tick();
    if (fft_en && fft_start && !fft_busy) begin
      tick_n(2);
      fft_busy = 1'b1;
      tick_n(10);
      fft_busy = 1'b0;
    end
  end

  // TX master IF: 8 beats with random TREADY stalls, then TLAST held 5 cycles before busy drops
  always begin : tx_model
    tick();
    if (tx_start && !tx_busy) begin
      tick_n(2);
      tx_busy = 1'b1;
      if (tx_rand) begin
        for (int b = 0; b < 8; b++) begin
          tick();
          if ($urandom_range(0, 2) == 0) tick();
        end
        tick_n(5);
      end else begin
        tick_n(10);
      end
      tx_busy = 1'b0;
    end
  end

  // Protocol monitor: pulse counts, request overlap, early TX exit, ownership and request order logs
  always @(negedge clk) begin
    n_fd       <= n_fd + int'(frame_done);
    n_done_cyc <= n_done_cyc + int'(all_done);
    if (int'(rx_start) + int'(fft_start) + int'(tx_start) > 1) n_ovl <= n_ovl + 1;
    if (frame_done && prev_txb) n_early <= n_early + 1;
    prev_txb <= tx_busy;
    if (mem_sel != prev_ms) ms_log.push_back(mem_sel);
    prev_ms <= mem_sel;
    if (rx_start && !prev_st[0]) st_log.push_back(2'd1);
    if (fft_start && !prev_st[1]) st_log.push_back(2'd2);
    if (tx_start && !prev_st[2]) st_log.push_back(2'd3);
    prev_st <= {tx_start, fft_start, rx_start};
  end

  initial begin
    int ms0, st0, fd0, dc0, cnt;
    logic [7:0] seq8;
    logic [5:0] seq6;

    rst_n       = 1'b0;
    cfg_en      = 1'b0;
    cfg_frames  = '0;
    cfg_clr_err = 1'b0;
    tick_n(3);
    chk("reset_outputs", 32'(all_outs), 0);

    // single frame
    rst_n = 1'b1;
    tick();
    ms0 = ms_log.size();
    st0 = st_log.size();
    fd0 = n_fd;
    cfg_frames = 4'd1;
    cfg_en     = 1'b1;
    tick();
    chk("t1_rx_start", 32'(rx_start), 1);
    chk("t1_mem_sel_rx", 32'(mem_sel), 1);
    chk("t1_sched_busy", 32'(sched_busy), 1);
    wait_done(300);
    chk("t1_all_done", 32'(all_done), 1);
    chk("t1_frames_done", 32'(frames_done), 1);
    chk("t1_mem_sel_done", 32'(mem_sel), 0);
    chk("t1_busy_done", 32'(sched_busy), 0);
    tick_n(2);
    chk("t1_ms_changes", 32'(ms_log.size() - ms0), 4);
    seq8 = (ms_log.size() >= ms0 + 4) ?
           {ms_log[ms0], ms_log[ms0+1], ms_log[ms0+2], ms_log[ms0+3]} : 8'hFF;
    chk("t1_ms_seq", 32'(seq8), 32'h6C);
    chk("t1_starts", 32'(st_log.size() - st0), 3);
    seq6 = (st_log.size() >= st0 + 3) ? {st_log[st0], st_log[st0+1], st_log[st0+2]} : 6'h3F;
    chk("t1_start_seq", 32'(seq6), 32'h1B);
    chk("t1_pulses", 32'(n_fd - fd0), 1);
    cfg_en = 1'b0;
    tick_n(2);
    chk("t1_idle_all_done", 32'(all_done), 0);

    // three frames with TX backpressure
    tx_rand = 1'b1;
    fd0 = n_fd;
    cfg_frames = 4'd3;
    cfg_en     = 1'b1;
    wait_done(1500);
    chk("t2_all_done", 32'(all_done), 1);
    chk("t2_frames_done", 32'(frames_done), 3);
    tick_n(2);
    chk("t2_pulses", 32'(n_fd - fd0), 3);
    chk("t2_overlap", 32'(n_ovl), 0);
    chk("t2_early_exit", 32'(n_early), 0);
    cfg_en  = 1'b0;
    tx_rand = 1'b0;
    tick_n(2);

    // continuous, enable dropped during FFT_RUN of frame 2
    fd0 = n_fd;
    dc0 = n_done_cyc;
    cfg_frames = 4'd0;
    cfg_en     = 1'b1;
    for (int i = 0; i < 300 && (n_fd - fd0) < 1; i++) tick();
    for (int i = 0; i < 300 && !(phase == 2'd2 && !fft_start && fft_busy); i++) tick();
    cfg_en = 1'b0;
    for (int i = 0; i < 300 && sched_busy; i++) tick();
    tick();
    chk("t3_frames_done", 32'(frames_done), 2);
    chk("t3_pulses", 32'(n_fd - fd0), 2);
    chk("t3_phase", 32'(phase), 0);
    chk("t3_all_done", 32'(all_done), 0);
    tick_n(5);
    chk("t3_stays_idle", 32'(rx_start), 0);

    // continuous wrap: 17 frames on a 4-bit counter
    fd0 = n_fd;
    cfg_en = 1'b1;
    for (int i = 0; i < 2000 && (n_fd - fd0) < 16; i++) tick();
    cfg_en = 1'b0;
    for (int i = 0; i < 300 && sched_busy; i++) tick();
    tick();
    chk("t4_pulses", 32'(n_fd - fd0), 17);
    chk("t4_frames_wrap", 32'(frames_done), 1);
    chk("t4_no_done", 32'(n_done_cyc - dc0), 0);

    // reset asserted during TX_RUN of frame 2, then a clean restart
    fd0 = n_fd;
    cfg_en = 1'b1;
    for (int i = 0; i < 300 && (n_fd - fd0) < 1; i++) tick();
    for (int i = 0; i < 300 && !(phase == 2'd3 && !tx_start && tx_busy); i++) tick();
    chk("t5_pre_frames", 32'(frames_done), 1);
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    tick();
    chk("t5_reset_outputs", 32'(all_outs), 0);
    for (int i = 0; i < 100 && tx_busy; i++) tick();
    tick();
    rst_n = 1'b1;
    tick();
    fd0 = n_fd;
    cfg_frames = 4'd1;
    cfg_en     = 1'b1;
    wait_done(300);
    chk("t5_restart_done", 32'(all_done), 1);
    chk("t5_restart_frames", 32'(frames_done), 1);
    tick_n(2);
    chk("t5_restart_pulses", 32'(n_fd - fd0), 1);
    cfg_en = 1'b0;
    tick_n(2);

    // FFT engine never answers
    fft_en = 1'b0;
    cfg_en = 1'b1;
    for (int i = 0; i < 100 && !fft_start; i++) tick();
    chk("t6_fft_req", 32'(fft_start), 1);
`ifdef FFT_SCHED_WDOG_EN
    cnt = 0;
    for (int i = 0; i < 200 && !err; i++) begin
      tick();
      cnt++;
    end
    chk("t6_wdog_cycles", 32'(cnt), 64);
    chk("t6_err", 32'(err), 1);
    chk("t6_fft_start", 32'(fft_start), 0);
    chk("t6_mem_sel", 32'(mem_sel), 0);
    cfg_en = 1'b0;
    tick_n(3);
    chk("t6_err_sticky", 32'(err), 1);
    cfg_clr_err = 1'b1;
    tick();
    cfg_clr_err = 1'b0;
    chk("t6_err_cleared", 32'(err), 0);
    tick();
    chk("t6_idle", 32'(sched_busy), 0);
`else
    cnt = 0;
    tick_n(200);
    chk("t6_hold_req", 32'(fft_start), 1);
    chk("t6_hold_phase", 32'(phase), 2);
    chk("t6_no_err", 32'(err), 0);
    cfg_en = 1'b0;
    rst_n  = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick();
`endif
    fft_en = 1'b1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
Frame-level scheduler for the FFT core and its AXI-stream I/O blocks. It runs each frame in a fixed order: RX (slave IF fills FFT memory), then FFT compute, then TX (master IF drains memory). Each sub-block is started with a level request and its busy flag is tracked. The scheduler also owns the select for the shared FFT memory port and counts frames for the PS-side register file.

Parameters:
FRAME_CNT_WDT, 16, width of frame-count config and status
WDOG_CYC, 65536, watchdog limit in cycles per phase (used only with FFT_SCHED_WDOG_EN)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_en  in  1  run enable (level)
cfg_frames  in  FRAME_CNT_WDT  frames to process; 0 = continuous
cfg_clr_err  in  1  clears sticky error (pulse)
rx_start  out  1  request to AXIS slave IF
rx_busy  in  1  slave IF busy
fft_start  out  1  request to FFT engine
fft_busy  in  1  FFT engine busy
tx_start  out  1  request to AXIS master IF
tx_busy  in  1  master IF busy (m_axis_if_busy)
mem_sel  out  2  FFT memory port owner: 0 none, 1 RX, 2 FFT, 3 TX
phase  out  2  0 idle/done/err, 1 RX, 2 FFT, 3 TX
sched_busy  out  1  high in every state except IDLE, DONE and ERR
frame_done  out  1  one-cycle pulse per completed frame
frames_done  out  FRAME_CNT_WDT  completed-frame count
all_done  out  1  high in DONE
err  out  1  sticky watchdog error

Behaviour:
- Reset values: every output 0; state IDLE.
- States: IDLE, RX_REQ, RX_RUN, FFT_REQ, FFT_RUN, TX_REQ, TX_RUN, DONE, ERR.
- All outputs are registered. The state machine is a single registered process.
- IDLE -> RX_REQ when cfg_en=1. frames_done clears to 0 on this transition only.
- x_REQ state:
  - x_start=1 and mem_sel=x.
  - Move to x_RUN on the first cycle x_busy=1.
  - x_start drops on the cycle the state enters x_RUN.
  - A request held for many cycles is legal; the master IF accepts only when its read side is idle.
- x_RUN state:
  - mem_sel stays at x.
  - Move to the next REQ on the first cycle x_busy=0.
  - Phase completion is the busy falling edge, not tx_done; TLAST can be held for several cycles under backpressure.
- RX_RUN -> FFT_REQ; FFT_RUN -> TX_REQ.
- TX_RUN exit, on tx_busy=0:
  - frame_done=1 for one cycle and frames_done increments.
  - If cfg_frames!=0 and frames_done+1==cfg_frames -> DONE.
  - Else if cfg_en=1 -> RX_REQ.
  - Else -> IDLE.
- mem_sel ownership:
  - mem_sel changes only on entry to a REQ state or to IDLE, DONE or ERR.
  - Exactly one owner at a time; no cycle with two owners.
  - At most one *_start is high at any time.
- cfg_en dropped mid-frame: the current frame completes in full, then IDLE.
- cfg_frames changed mid-run: sampled only at the TX_RUN exit.
- DONE: all_done=1, mem_sel=0; -> IDLE when cfg_en=0.
- Continuous mode (cfg_frames=0): frames_done wraps 2^FRAME_CNT_WDT-1 -> 0 and never enters DONE.
- Busy already high when a REQ state is entered: transition to RUN on the next cycle. This is legal.
- Reset mid-operation: every output returns to 0 on the next edge and the state returns to IDLE. Sub-blocks are reset by the same rst_n.

Optional Feature:
Macro FFT_SCHED_WDOG_EN.
- Defined:
  - A 32-bit watchdog counter clears on every state entry and increments in REQ and RUN states.
  - When the count reaches WDOG_CYC-1: go to ERR. In ERR all *_start=0, mem_sel=0, err=1.
  - err is sticky. ERR -> IDLE on cfg_clr_err=1, which also clears err.
  - cfg_clr_err outside ERR has no effect.
- Not defined: no counter; err tied 0; ERR unreachable.

Test Plan:
- cfg_frames=1, cfg_en=1, each model busy for 10 cycles after its request:
  - Sequence: rx_start, then fft_start, then tx_start.
  - mem_sel sequence 1, 2, 3, then 0.
  - frame_done once; frames_done=1; all_done=1.
- cfg_frames=3 with random TREADY backpressure on the master-IF model:
  - Exactly 3 frame_done pulses; frames_done=3; DONE entered.
  - No request overlap.
  - tx_done held for 5 cycles does not cause an early exit.
- Continuous mode, cfg_en dropped during FFT_RUN of frame 2:
  - TX of frame 2 completes; frames_done=2; state IDLE; all_done=0.
- Continuous mode with FRAME_CNT_WDT=4: after 17 frames frames_done=1 (wrap); DONE never entered.
- Reset asserted in TX_RUN: on the next cycle all outputs are 0 and state is IDLE. A restart then runs a full frame correctly.
- With FFT_SCHED_WDOG_EN, WDOG_CYC=64, fft_busy never asserted:
  - ERR after 64 cycles in FFT_REQ; err=1; fft_start=0.
  - cfg_clr_err pulse -> IDLE, err=0.
  - Without the macro, the same stimulus holds FFT_REQ indefinitely with err=0.
